// File: rtl/aes_round_engine.sv
// rtl/aes_round_engine.sv - iterative AES-128/192/256 round engine, one round per clock.
// Optional macro AES_DECRYPT_EN adds the dec port and the FIPS-197 inverse cipher.
`timescale 1ns/1ps
module aes_round_engine #(
  parameter int KEY_BITS = 128,
  parameter int RIDX_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      in_block,
  output logic [RIDX_W-1:0] rk_idx,
  input  logic [127:0]      rk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      out_block
`ifdef AES_DECRYPT_EN
  ,
  input  logic              dec
`endif
);

  localparam int NR = 6 + KEY_BITS / 32;
  localparam logic [RIDX_W-1:0] NR_IDX = RIDX_W'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_round_engine: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] a2, a3, a12, a15, a240;
    a2   = gmul(a, a);
    a3   = gmul(a2, a);
    a12  = gmul(gmul(a3, a3), gmul(a3, a3));
    a15  = gmul(a12, a3);
    a240 = gmul(gmul(gmul(a15, a15), gmul(a15, a15)), gmul(gmul(a15, a15), gmul(a15, a15)));
    a240 = gmul(a240, a240);
    a240 = gmul(gmul(a15, a15), gmul(a15, a15));
    a240 = gmul(a240, a240);
    a240 = gmul(a240, a240);
    return gmul(gmul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = sbox(x[127-8*i -: 8]);
    return y;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      y[119-32*c -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      y[111-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      y[103-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return y;
  endfunction

`ifdef AES_DECRYPT_EN
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = inv_sbox(x[127-8*i -: 8]);
    return y;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c-r+4)%4)+r) -: 8];
    return y;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      y[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      y[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      y[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return y;
  endfunction
`endif

  fsm_t              r_fsm;
  logic [RIDX_W-1:0] r_rnd;
  logic [127:0]      r_state;
  logic [127:0]      r_out_block;
  logic              r_out_valid;
  logic              w_accept;
  logic              w_last;
  logic [127:0]      w_enc_sr;
  logic [127:0]      w_enc_next;
  logic [127:0]      w_round_next;
  logic [RIDX_W-1:0] w_start_idx;
  logic [RIDX_W-1:0] w_rk_idx;

  assign in_ready  = reset_n & ((r_fsm == S_IDLE) | ((r_fsm == S_DONE) & out_ready));
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_rnd >= NR_IDX);
  assign out_valid = r_out_valid;
  assign out_block = r_out_block;
  assign rk_idx    = w_rk_idx;

  assign w_enc_sr   = shift_rows(sub_bytes(r_state));
  assign w_enc_next = (w_last ? w_enc_sr : mix_columns(w_enc_sr)) ^ rk;

`ifdef AES_DECRYPT_EN
  logic         r_dec;
  logic [127:0] w_dec_ark;
  assign w_dec_ark    = inv_sub_bytes(inv_shift_rows(r_state)) ^ rk;
  assign w_round_next = r_dec ? (w_last ? w_dec_ark : inv_mix_columns(w_dec_ark)) : w_enc_next;
  assign w_start_idx  = dec ? NR_IDX : '0;
`else
  assign w_round_next = w_enc_next;
  assign w_start_idx  = '0;
`endif

  // rk_idx depends only on registered state (plus dec while waiting for a block).
  always_comb begin
    w_rk_idx = w_start_idx;
    if (r_fsm == S_ROUND) begin
`ifdef AES_DECRYPT_EN
      w_rk_idx = r_dec ? (NR_IDX - r_rnd) : r_rnd;
`else
      w_rk_idx = r_rnd;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fsm       <= S_IDLE;
      r_rnd       <= '0;
      r_state     <= '0;
      r_out_block <= '0;
      r_out_valid <= 1'b0;
`ifdef AES_DECRYPT_EN
      r_dec       <= 1'b0;
`endif
    end else if (abort) begin
      r_fsm       <= S_IDLE;
      r_rnd       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_fsm)
        S_IDLE, S_DONE: begin
          if (r_fsm == S_DONE && out_ready) begin
            r_out_valid <= 1'b0;
            r_fsm       <= S_IDLE;
          end
          if (w_accept) begin
            r_state <= in_block ^ rk;
            r_rnd   <= RIDX_W'(1);
            r_fsm   <= S_ROUND;
`ifdef AES_DECRYPT_EN
            r_dec   <= dec;
`endif
          end
        end
        S_ROUND: begin
          r_state <= w_round_next;
          if (w_last) begin
            r_out_block <= w_round_next;
            r_out_valid <= 1'b1;
            r_rnd       <= '0;
            r_fsm       <= S_DONE;
          end else begin
            r_rnd <= r_rnd + 1'b1;
          end
        end
        default: begin
          r_fsm       <= S_IDLE;
          r_rnd       <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_engine.sv
// tb/tb_aes_round_engine.sv - directed vector bench for aes_round_engine at 128/192/256-bit keys.
// Builds round keys itself and checks against published FIPS-197 / SP800-38A ciphertexts.
`timescale 1ns/1ps
module tb_aes_round_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         abort_v     [3];
  logic         in_valid_v  [3];
  logic         in_ready_v  [3];
  logic         out_valid_v [3];
  logic         out_ready_v [3];
  logic [127:0] in_block_v  [3];
  logic [127:0] rk_v        [3];
  logic [127:0] out_block_v [3];
  logic [3:0]   rk_idx_v    [3];
`ifdef AES_DECRYPT_EN
  logic         dec_v       [3];
`endif
  logic [127:0] rkeys [3][16];
  logic [7:0]   sbox  [256];
  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_round_engine #(.KEY_BITS(128 + 64 * g)) u_dut (
      .clk       (clk),
      .reset_n   (rst_n),
      .abort     (abort_v[g]),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .in_block  (in_block_v[g]),
      .rk_idx    (rk_idx_v[g]),
      .rk        (rk_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .out_block (out_block_v[g])
`ifdef AES_DECRYPT_EN
      ,
      .dec       (dec_v[g])
`endif
    );
    assign rk_v[g] = rkeys[g][rk_idx_v[g]];
  end

  typedef struct {
    int           g;
    logic [255:0] key;
    logic [127:0] din;
    logic [127:0] dout;
    logic         d;
  } vec_t;
  vec_t vecs[$];

  localparam logic [255:0] K_C1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K_C2  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] K_128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K_192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K_256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SP1   = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] SP2   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] SP3   = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] SP4   = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] SP1_C = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] SP2_C = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] SP3_C = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [127:0] SP4_C = 128'h7b0c785e27e8ad3f8223207104725dd4;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int k = 0; k < 255; k++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end
    sbox[0] = 8'h63;
  endtask

  task automatic load_key(input int g, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr;
    nk = 4 + 2 * g;
    nr = 10 + 2 * g;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk > 6 && i % nk == 4) begin
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < 16; j++)
      rkeys[g][j] = (j <= nr) ? {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]} : 128'h0;
  endtask

  function automatic logic [3:0] exp_idx(input logic d, input int nr, input int i);
    return d ? 4'(nr - i) : 4'(i);
  endfunction

  // Presents a block, then follows it to out_valid, recording latency and rk_idx order.
  task automatic run_block(input int g, input logic [127:0] blk, input logic d,
                           output logic [127:0] res, output int lat, output logic seq_ok);
    int nr;
    int waitc;
    nr = 10 + 2 * g;
    seq_ok = 1'b1;
    waitc = 0;
    @(negedge clk);
    in_valid_v[g]  = 1'b1;
    in_block_v[g]  = blk;
    out_ready_v[g] = 1'b0;
`ifdef AES_DECRYPT_EN
    dec_v[g] = d;
`endif
    while (!in_ready_v[g] && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (rk_idx_v[g] !== exp_idx(d, nr, 0)) seq_ok = 1'b0;
    @(posedge clk);
    #1;
    in_valid_v[g] = 1'b0;
    lat = 1;
    while (!out_valid_v[g] && lat < 40) begin
      if (rk_idx_v[g] !== exp_idx(d, nr, lat)) seq_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    res = out_block_v[g];
  endtask

  task automatic release_out(input int g);
    @(negedge clk);
    out_ready_v[g] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[g] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res;
    int           lat;
    logic         seq_ok;
    logic         flag;
    int           n;

    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      abort_v[g]     = 1'b0;
      in_valid_v[g]  = 1'b0;
      out_ready_v[g] = 1'b0;
      in_block_v[g]  = '0;
`ifdef AES_DECRYPT_EN
      dec_v[g] = 1'b0;
`endif
    end
    build_sbox();
    for (int g = 0; g < 3; g++) load_key(g, 256'h0);

    vecs.push_back('{0, K_C1,  PT_C, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0});
    vecs.push_back('{1, K_C2,  PT_C, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 1'b0});
    vecs.push_back('{2, K_C3,  PT_C, 128'h8ea2b7ca516745bfeafc49904b496089, 1'b0});
    vecs.push_back('{0, K_128, 128'h3243f6a8885a308d313198a2e0370734,
                     128'h3925841d02dc09fbdc118597196a0b32, 1'b0});
    vecs.push_back('{0, K_128, SP1, SP1_C, 1'b0});
    vecs.push_back('{1, K_192, SP1, 128'hbd334f1d6e45f25ff712a214571fa5cc, 1'b0});
    vecs.push_back('{2, K_256, SP1, 128'hf3eed1bdb5d2a03c064b5a7e3db181f8, 1'b0});
`ifdef AES_DECRYPT_EN
    vecs.push_back('{0, K_C1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, PT_C, 1'b1});
    vecs.push_back('{1, K_C2, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, PT_C, 1'b1});
    vecs.push_back('{2, K_C3, 128'h8ea2b7ca516745bfeafc49904b496089, PT_C, 1'b1});
`endif

    repeat (2) @(negedge clk);
    check("reset_out_valid", 128'(out_valid_v[0]), 128'h0);
    check("reset_out_block", out_block_v[0], 128'h0);
    check("reset_in_ready",  128'(in_ready_v[0]), 128'h0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", 128'(in_ready_v[0]), 128'h1);
    check("idle_rk_idx",   128'(rk_idx_v[0]), 128'h0);

    foreach (vecs[i]) begin
      load_key(vecs[i].g, vecs[i].key);
      run_block(vecs[i].g, vecs[i].din, vecs[i].d, res, lat, seq_ok);
      check($sformatf("vec%0d_block", i), res, vecs[i].dout);
      check($sformatf("vec%0d_latency", i), 128'(lat), 128'(11 + 2 * vecs[i].g));
      check($sformatf("vec%0d_rk_idx_seq", i), 128'(seq_ok), 128'h1);
      release_out(vecs[i].g);
      check($sformatf("vec%0d_released", i), 128'(out_valid_v[vecs[i].g]), 128'h0);
    end

    // Backpressure for 20 cycles, then handshake and new accept on the same edge.
    load_key(0, K_128);
    run_block(0, SP1, 1'b0, res, lat, seq_ok);
    check("bp_first_block", res, SP1_C);
    flag = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_block_v[0] !== SP1_C || in_ready_v[0] !== 1'b0 || out_valid_v[0] !== 1'b1) flag = 1'b0;
    end
    check("bp_hold_stable", 128'(flag), 128'h1);
    @(negedge clk);
    out_ready_v[0] = 1'b1;
    in_valid_v[0]  = 1'b1;
    in_block_v[0]  = SP2;
    #1;
    check("b2b_in_ready", 128'(in_ready_v[0]), 128'h1);
    check("b2b_rk_idx0",  128'(rk_idx_v[0]), 128'h0);
    @(posedge clk);
    #1;
    in_valid_v[0]  = 1'b0;
    out_ready_v[0] = 1'b0;
    check("b2b_out_valid_clr", 128'(out_valid_v[0]), 128'h0);
    check("b2b_no_bubble",     128'(rk_idx_v[0]), 128'h1);
    check("b2b_busy",          128'(in_ready_v[0]), 128'h0);
    lat = 1;
    while (!out_valid_v[0] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("b2b_latency", 128'(lat), 128'd11);
    check("b2b_block", out_block_v[0], SP2_C);

    // Abort beats a simultaneous output handshake and accept.
    @(negedge clk);
    out_ready_v[0] = 1'b1;
    in_valid_v[0]  = 1'b1;
    in_block_v[0]  = SP3;
    abort_v[0]     = 1'b1;
    @(posedge clk);
    #1;
    out_ready_v[0] = 1'b0;
    in_valid_v[0]  = 1'b0;
    abort_v[0]     = 1'b0;
    check("abort_vs_accept_idle", 128'(in_ready_v[0]), 128'h1);
    check("abort_vs_accept_ov",   128'(out_valid_v[0]), 128'h0);

    // Abort at round 5.
    @(negedge clk);
    in_valid_v[0] = 1'b1;
    in_block_v[0] = SP3;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    n = 0;
    while (rk_idx_v[0] !== 4'd5 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("abort_reach_round5", 128'(rk_idx_v[0]), 128'h5);
    @(negedge clk);
    abort_v[0] = 1'b1;
    @(posedge clk);
    #1;
    abort_v[0] = 1'b0;
    check("abort_in_ready",  128'(in_ready_v[0]), 128'h1);
    check("abort_keeps_out", out_block_v[0], SP2_C);
    flag = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid_v[0] !== 1'b0) flag = 1'b0;
    end
    check("abort_no_out_valid", 128'(flag), 128'h1);
    run_block(0, SP3, 1'b0, res, lat, seq_ok);
    check("after_abort_block", res, SP3_C);
    release_out(0);

    // Asynchronous reset pulse between clock edges in mid-round.
    @(negedge clk);
    in_valid_v[0] = 1'b1;
    in_block_v[0] = SP4;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 128'(out_valid_v[0]), 128'h0);
    check("async_rst_out_block", out_block_v[0], 128'h0);
    check("async_rst_rk_idx",    128'(rk_idx_v[0]), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(0, SP4, 1'b0, res, lat, seq_ok);
    check("after_reset_block",   res, SP4_C);
    check("after_reset_latency", 128'(lat), 128'd11);
    release_out(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
